// File: rtl/gcn_agg_pkg.sv
// Shared types and helpers for the GCN COO aggregation stage.
// FSM state encoding, decoded COO index record and the index decoder.
package gcn_agg_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_EDGE_SRC,
        S_EDGE_DST,
        S_ARGMAX,
        S_DONE
    } agg_state_t;

    typedef struct packed {
        logic        ok;
        logic [31:0] idx;
    } coo_idx_t;

    // Base subtract then range check; 0 - 1 wraps high and is rejected.
    function automatic coo_idx_t coo_decode(
        input logic [31:0] raw,
        input logic [31:0] base,
        input logic [31:0] nodes
    );
        coo_idx_t r;
        r.idx = raw - base;
        r.ok  = (r.idx < nodes);
        return r;
    endfunction

endpackage

// File: rtl/gcn_argmax_row.sv
// Combinational argmax over one accumulator row.
// Strict greater-than compare so a tie keeps the lowest lane index.
module gcn_argmax_row #(
    parameter int NUM_CLASSES       = 3,
    parameter int ACC_WIDTH         = 20,
    parameter int MAX_ADDRESS_WIDTH = 2
) (
    input  logic [NUM_CLASSES-1:0][ACC_WIDTH-1:0] lanes,
    output logic [MAX_ADDRESS_WIDTH-1:0]          max_idx
);

    logic [ACC_WIDTH-1:0] best;

    // Linear scan, first maximum wins
    always_comb begin
        best    = lanes[0];
        max_idx = '0;
        for (int i = 1; i < NUM_CLASSES; i++) begin
            if (lanes[i] > best) begin
                best    = lanes[i];
                max_idx = MAX_ADDRESS_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/gcn_coo_aggregator.sv
// GCN aggregation: (A + I) * (FM*WM) over a COO edge list, then argmax per node.
// Optional macro GCN_AGG_SATURATE_EN: clamping adds plus sticky sat_flag output.
module gcn_coo_aggregator
    import gcn_agg_pkg::*;
#(
    parameter int NUM_OF_NODES      = 6,
    parameter int NUM_OF_EDGES      = 6,
    parameter int NUM_CLASSES       = 3,
    parameter int DOT_PROD_WIDTH    = 16,
    parameter int ACC_WIDTH         = 20,
    parameter int COO_BW            = (NUM_OF_EDGES > 1) ? $clog2(NUM_OF_EDGES) : 1,
    parameter int NODE_BW           = (NUM_OF_NODES > 1) ? $clog2(NUM_OF_NODES) : 1,
    parameter int MAX_ADDRESS_WIDTH = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1,
    parameter int COO_ONE_BASED     = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    output logic [COO_BW-1:0]            coo_address,
    input  logic [2*COO_BW-1:0]          coo_in,
    output logic [NODE_BW-1:0]           fmwm_address,
    input  logic [DOT_PROD_WIDTH-1:0]    fmwm_row_in [NUM_CLASSES],
    output logic                         done,
    output logic                         index_error,
`ifdef GCN_AGG_SATURATE_EN
    output logic                         sat_flag,
`endif
    output logic [MAX_ADDRESS_WIDTH-1:0] max_addi_answer [NUM_OF_NODES]
);

    typedef logic [NUM_CLASSES-1:0][ACC_WIDTH-1:0] acc_row_t;

    localparam logic [NODE_BW-1:0] LAST_NODE = NODE_BW'(NUM_OF_NODES - 1);
    localparam logic [COO_BW-1:0]  LAST_EDGE = COO_BW'(NUM_OF_EDGES - 1);

    agg_state_t                   state;
    logic [NODE_BW-1:0]           node_cnt;
    acc_row_t                     acc [NUM_OF_NODES];
    coo_idx_t                     src_dec;
    coo_idx_t                     dst_dec;
    logic                         edge_ok;
    logic [NODE_BW-1:0]           src_n;
    logic [NODE_BW-1:0]           dst_n;
    logic [NODE_BW-1:0]           tgt_n;
    acc_row_t                     sum_row;
    logic [MAX_ADDRESS_WIDTH-1:0] arg_idx;
    logic                         unused_hi;
`ifdef GCN_AGG_SATURATE_EN
    logic                         sat_hit;
    logic [ACC_WIDTH:0]           lane_sum;
`endif

    assign src_dec = coo_decode(32'(coo_in[2*COO_BW-1:COO_BW]),
                                32'(COO_ONE_BASED), 32'(NUM_OF_NODES));
    assign dst_dec = coo_decode(32'(coo_in[COO_BW-1:0]),
                                32'(COO_ONE_BASED), 32'(NUM_OF_NODES));
    assign src_n   = src_dec.idx[NODE_BW-1:0];
    assign dst_n   = dst_dec.idx[NODE_BW-1:0];
    assign edge_ok = src_dec.ok & dst_dec.ok;
    assign tgt_n   = (state == S_EDGE_DST) ? dst_n : src_n;
    assign unused_hi = ^{src_dec.idx[31:NODE_BW], dst_dec.idx[31:NODE_BW]};

    // Row address follows the COO entry in the same cycle
    always_comb begin
        fmwm_address = '0;
        case (state)
            S_INIT:     fmwm_address = node_cnt;
            S_EDGE_SRC: fmwm_address = dst_n;
            S_EDGE_DST: fmwm_address = src_n;
            default:    fmwm_address = '0;
        endcase
    end

    // Lane-wise add of the fetched row into the target accumulator
    always_comb begin
        sum_row = acc[tgt_n];
`ifdef GCN_AGG_SATURATE_EN
        sat_hit  = 1'b0;
        lane_sum = '0;
`endif
        for (int c = 0; c < NUM_CLASSES; c++) begin
`ifdef GCN_AGG_SATURATE_EN
            lane_sum = {1'b0, acc[tgt_n][c]}
                     + (ACC_WIDTH + 1)'(fmwm_row_in[c]);
            if (lane_sum[ACC_WIDTH]) begin
                sum_row[c] = '1;
                sat_hit    = 1'b1;
            end else begin
                sum_row[c] = lane_sum[ACC_WIDTH-1:0];
            end
`else
            sum_row[c] = acc[tgt_n][c] + ACC_WIDTH'(fmwm_row_in[c]);
`endif
        end
    end

    gcn_argmax_row #(
        .NUM_CLASSES       (NUM_CLASSES),
        .ACC_WIDTH         (ACC_WIDTH),
        .MAX_ADDRESS_WIDTH (MAX_ADDRESS_WIDTH)
    ) u_argmax (
        .lanes   (acc[node_cnt]),
        .max_idx (arg_idx)
    );

    // Control FSM with accumulator and result storage
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            node_cnt    <= '0;
            coo_address <= '0;
            done        <= 1'b0;
            index_error <= 1'b0;
`ifdef GCN_AGG_SATURATE_EN
            sat_flag    <= 1'b0;
`endif
            for (int n = 0; n < NUM_OF_NODES; n++) begin
                acc[n]             <= '0;
                max_addi_answer[n] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        for (int n = 0; n < NUM_OF_NODES; n++) acc[n] <= '0;
                        index_error <= 1'b0;
`ifdef GCN_AGG_SATURATE_EN
                        sat_flag    <= 1'b0;
`endif
                        done        <= 1'b0;
                        node_cnt    <= '0;
                        coo_address <= '0;
                        state       <= S_INIT;
                    end
                end
                S_INIT: begin
                    for (int c = 0; c < NUM_CLASSES; c++)
                        acc[node_cnt][c] <= ACC_WIDTH'(fmwm_row_in[c]);
                    if (node_cnt == LAST_NODE) begin
                        node_cnt <= '0;
                        state    <= S_EDGE_SRC;
                    end else begin
                        node_cnt <= node_cnt + NODE_BW'(1);
                    end
                end
                S_EDGE_SRC: begin
                    if (edge_ok) acc[src_n] <= sum_row;
                    else         index_error <= 1'b1;
`ifdef GCN_AGG_SATURATE_EN
                    if (edge_ok && sat_hit) sat_flag <= 1'b1;
`endif
                    state <= S_EDGE_DST;
                end
                S_EDGE_DST: begin
                    if (edge_ok) acc[dst_n] <= sum_row;
                    else         index_error <= 1'b1;
`ifdef GCN_AGG_SATURATE_EN
                    if (edge_ok && sat_hit) sat_flag <= 1'b1;
`endif
                    if (coo_address == LAST_EDGE) begin
                        coo_address <= '0;
                        state       <= S_ARGMAX;
                    end else begin
                        coo_address <= coo_address + COO_BW'(1);
                        state       <= S_EDGE_SRC;
                    end
                end
                S_ARGMAX: begin
                    max_addi_answer[node_cnt] <= arg_idx;
                    if (node_cnt == LAST_NODE) begin
                        node_cnt <= '0;
                        state    <= S_DONE;
                    end else begin
                        node_cnt <= node_cnt + NODE_BW'(1);
                    end
                end
                S_DONE: begin
                    done <= 1'b1;
                    if (!start) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
